fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have parameter RESET_INSTRUCTION, default 32'h00000000: instruction value driven when no entry is valid.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries, power of two in 2..16; cap on queued plus outstanding plus discarded requests.
REQ-004 SHALL have ports: clk in 1, rising-edge clock, single clock domain; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: override in 1, redirect strobe; newpc in 32, redirect target.
REQ-006 SHALL have ports: mem_valid out 1, request; mem_ready in 1, request accepted; mem_addr out 32, word address.
REQ-007 SHALL have ports: mem_rvalid in 1, response strobe; mem_rdata in 32, response data.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; instruction out 32; outpc out 32, address of instruction.

Function
REQ-009 SHALL advance pc by 4 (32-bit wrap, 32'hFFFFFFFC to 0) on each accepted request (mem_valid and mem_ready); mem_addr SHALL equal pc.
REQ-010 SHALL drive mem_valid high only when rst and override are low, and queued + outstanding + discard < DEPTH.
REQ-011 SHALL accept exactly one in-order mem_rvalid per accepted request, at least 1 cycle after acceptance, with any latency.
REQ-012 SHALL write a non-discarded response into the queue tail with its request address; out_valid SHALL rise the cycle after mem_rvalid, with no combinational bypass.
REQ-013 SHALL present the head entry on instruction/outpc while out_valid is high and pop it on out_valid and out_ready; with out_valid low, instruction SHALL be RESET_INSTRUCTION and outpc SHALL be RESET_PC.
REQ-014 SHALL, on override, set pc to {newpc[31:2],2'b00}, empty the queue, and add all outstanding requests to a discard counter.
REQ-015 SHALL drop each mem_rvalid while discard > 0 and decrement discard.
REQ-016 SHALL give override priority: same-cycle pop is void; a same-cycle mem_rvalid counts as discarded; no request is issued in the override cycle.
REQ-017 SHALL, with the queue full and out_ready low, hold all entries and keep mem_valid low; a same-cycle pop and response SHALL keep the count unchanged.
REQ-018 SHALL achieve a minimum redirect-to-out_valid latency of 3 cycles (override N, request N+1, response N+2, out_valid N+3).

Reset
REQ-019 SHALL, while rst is high: pc=RESET_PC, queue empty, outstanding=0, discard=0, out_valid=0, mem_valid=0, instruction=RESET_INSTRUCTION, outpc=RESET_PC.
REQ-020 SHALL issue the first request at RESET_PC in the first cycle after rst deasserts if mem_ready is high.
REQ-021 SHALL ignore mem_rvalid arriving during reset or after reset for requests issued before reset.

Configuration
REQ-022 SHALL, with macro FETCH_MISALIGN_EN defined, add output misaligned (1 bit).
REQ-023 SHALL, with FETCH_MISALIGN_EN defined and override with newpc[1:0]!=0, enter state TRAP: queue flushed, one entry with misaligned=1, instruction=RESET_INSTRUCTION, outpc=newpc (unaligned); no requests until the next override returns state to FETCH.
REQ-024 SHALL, with FETCH_MISALIGN_EN undefined, have no misaligned port and no TRAP state; newpc[1:0] is ignored per REQ-014.

Verification
REQ-025 Bench: reset, mem_ready=1, 1-cycle response latency, out_ready=1 -> outpc 0,4,8,12 on consecutive cycles; first out_valid 2 cycles after the first request.
REQ-026 Bench: DEPTH=4, out_ready=0 -> exactly 4 requests accepted, then mem_valid=0; out_ready=1 -> entries drain in order with addresses 0,4,8,12.
REQ-027 Bench: 3 outstanding at 3-cycle latency, override newpc=32'h100 -> 3 responses dropped; first out_valid shows outpc=32'h100.
REQ-028 Bench: override in the same cycle as mem_rvalid and a pop -> the response is dropped, the queue is empty, and mem_addr=newpc next cycle.
REQ-029 Bench: pc at 32'hFFFFFFFC -> next mem_addr=32'h00000000.
REQ-030 Bench: FETCH_MISALIGN_EN defined, override newpc=32'h102 -> one entry with misaligned=1, outpc=32'h102, mem_valid held 0; override newpc=32'h200 resumes fetch.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word requests, queues in-order responses, handles redirects.
// Define FETCH_MISALIGN_EN to add the misaligned output and the TRAP state on unaligned redirects.
module fetch_queue #(
    parameter logic [31:0] RESET_PC          = 32'h00000000,
    parameter logic [31:0] RESET_INSTRUCTION = 32'h00000000,
    parameter int          DEPTH             = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        override,
    input  logic [31:0] newpc,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
`ifdef FETCH_MISALIGN_EN
    output logic        misaligned,
`endif
    output logic [31:0] outpc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

`ifdef FETCH_MISALIGN_EN
    typedef enum logic {FETCH, TRAP} state_e;
    state_e      state_q, state_d;
    logic        trap_valid_q, trap_valid_d;
    logic [31:0] trap_pc_q, trap_pc_d;
`else
    logic        unused_newpc_lsbs;
    assign unused_newpc_lsbs = ^newpc[1:0];
`endif

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outs_q, outs_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];

    logic [CW+1:0] in_flight;
    logic          fetching;
    logic          accept;
    logic          resp_any;
    logic          resp_keep;
    logic          pop;
    logic          queue_pop;

    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        count_d   = count_q;
        outs_d    = outs_q;
        disc_d    = disc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        data_d    = data_q;
        addr_d    = addr_q;
`ifdef FETCH_MISALIGN_EN
        state_d      = state_q;
        trap_valid_d = trap_valid_q;
        trap_pc_d    = trap_pc_q;
        fetching     = (state_q == FETCH);
`else
        fetching     = 1'b1;
`endif

        // Every slot that is queued, in flight or awaiting a discarded response is reserved.
        in_flight = (CW+2)'(count_q) + (CW+2)'(outs_q) + (CW+2)'(disc_q);
        mem_valid = !rst && !override && fetching && (in_flight < DEPTH_W);
        mem_addr  = pc_q;
        accept    = mem_valid && mem_ready;

        // Discarded responses are always older than live ones, so they are consumed first.
        resp_any  = mem_rvalid && ((disc_q != '0) || (outs_q != '0));
        resp_keep = resp_any && (disc_q == '0);

        out_valid   = !rst && (count_q != '0);
        instruction = RESET_INSTRUCTION;
        outpc       = RESET_PC;
        if (!rst && (count_q != '0)) begin
            instruction = data_q[rd_ptr_q];
            outpc       = addr_q[rd_ptr_q];
        end
`ifdef FETCH_MISALIGN_EN
        misaligned = !rst && trap_valid_q;
        if (!rst && trap_valid_q) begin
            out_valid   = 1'b1;
            instruction = RESET_INSTRUCTION;
            outpc       = trap_pc_q;
        end
`endif
        pop       = out_valid && out_ready && !override;
        queue_pop = pop && (count_q != '0);

        if (override) begin
            pc_d     = {newpc[31:2], 2'b00};
            rsp_pc_d = {newpc[31:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = rd_ptr_q;
            outs_d   = '0;
            disc_d   = disc_q + outs_q - CW'(resp_any);
`ifdef FETCH_MISALIGN_EN
            if (newpc[1:0] != 2'b00) begin
                state_d      = TRAP;
                trap_valid_d = 1'b1;
                trap_pc_d    = newpc;
            end else begin
                state_d      = FETCH;
                trap_valid_d = 1'b0;
            end
`endif
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_keep) begin
                data_d[wr_ptr_q] = mem_rdata;
                addr_d[wr_ptr_q] = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rsp_pc_d         = rsp_pc_q + 32'd4;
            end
            if (resp_any && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
            outs_d  = outs_q + CW'(accept) - CW'(resp_keep);
            count_d = count_q + CW'(resp_keep) - CW'(queue_pop);
            if (queue_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
`ifdef FETCH_MISALIGN_EN
            if (pop && trap_valid_q) begin
                trap_valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            count_q  <= '0;
            outs_q   <= '0;
            disc_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
`ifdef FETCH_MISALIGN_EN
            state_q      <= FETCH;
            trap_valid_q <= 1'b0;
            trap_pc_q    <= RESET_PC;
`endif
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            count_q  <= count_d;
            outs_q   <= outs_d;
            disc_q   <= disc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef FETCH_MISALIGN_EN
            state_q      <= state_d;
            trap_valid_q <= trap_valid_d;
            trap_pc_q    <= trap_pc_d;
`endif
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model, in-order random-latency memory.
// Trap scenarios are exercised only when FETCH_MISALIGN_EN is defined.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h00000000;
    localparam logic [31:0] RINST = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        override = 1'b0;
    logic [31:0] newpc = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] outpc;
`ifdef FETCH_MISALIGN_EN
    logic        misaligned;
`endif

    fetch_queue #(.RESET_PC(RPC), .RESET_INSTRUCTION(RINST), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .override(override), .newpc(newpc),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
`ifdef FETCH_MISALIGN_EN
        .misaligned(misaligned),
`endif
        .outpc(outpc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;

    // Memory side: one response per accepted request, in order, at a due cycle.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;

    // Reference model: request records (live or to be dropped) and the visible queue.
    typedef struct packed {
        logic        live;
        logic [31:0] addr;
    } req_t;
    req_t        m_reqs[$];
    logic [31:0] m_outq[$];
    logic [31:0] m_pc = RPC;
    logic        m_trap = 1'b0;
    logic        m_trap_entry = 1'b0;
    logic [31:0] m_trap_pc = RPC;

    logic        obs_mem_valid, obs_out_valid, obs_mis;
    logic [31:0] obs_mem_addr, obs_outpc, obs_instr;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic        e_mv, e_ov, e_mis;
        logic [31:0] e_ins, e_pc;
        req_t        r;
        int          d;

        if (rst) begin
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = hash(pend_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #1;

        e_mv  = !rst && !override && !m_trap && ((m_outq.size() + m_reqs.size()) < DEPTH);
        e_ov  = !rst && (m_outq.size() > 0 || m_trap_entry);
        e_mis = e_ov && m_trap_entry;
        e_ins = RINST;
        e_pc  = RPC;
        if (e_ov) begin
            if (m_trap_entry) begin
                e_pc = m_trap_pc;
            end else begin
                e_ins = hash(m_outq[0]);
                e_pc  = m_outq[0];
            end
        end
        checkOutput("mem_valid", mem_valid, e_mv);
        if (e_mv) checkOutput("mem_addr", mem_addr, m_pc);
        checkOutput("out_valid", out_valid, e_ov);
        checkOutput("instruction", instruction, e_ins);
        checkOutput("outpc", outpc, e_pc);
`ifdef FETCH_MISALIGN_EN
        checkOutput("misaligned", misaligned, e_mis);
        obs_mis = misaligned;
`else
        obs_mis = e_mis;
`endif
        obs_mem_valid = mem_valid;
        obs_mem_addr  = mem_addr;
        obs_out_valid = out_valid;
        obs_outpc     = outpc;
        obs_instr     = instruction;

        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = cyc;
        end else begin
            if (mem_rvalid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (mem_valid && mem_ready) begin
                d = cyc + int'($urandom_range(lat_min, lat_max));
                if (d <= last_due) d = last_due + 1;
                pend_addr.push_back(mem_addr);
                pend_due.push_back(d);
                last_due = d;
            end
        end

        if (rst) begin
            m_reqs.delete();
            m_outq.delete();
            m_pc = RPC;
            m_trap = 1'b0;
            m_trap_entry = 1'b0;
        end else begin
            if (mem_rvalid && m_reqs.size() > 0) begin
                r = m_reqs.pop_front();
                if (r.live && !override) m_outq.push_back(r.addr);
            end
            if (override) begin
                m_outq.delete();
                foreach (m_reqs[i]) m_reqs[i].live = 1'b0;
                m_pc = {newpc[31:2], 2'b00};
                m_trap = 1'b0;
                m_trap_entry = 1'b0;
`ifdef FETCH_MISALIGN_EN
                if (newpc[1:0] != 2'b00) begin
                    m_trap = 1'b1;
                    m_trap_entry = 1'b1;
                    m_trap_pc = newpc;
                end
`endif
            end else begin
                if (e_ov && out_ready) begin
                    if (m_trap_entry) m_trap_entry = 1'b0;
                    else void'(m_outq.pop_front());
                end
                if (e_mv && mem_ready) begin
                    m_reqs.push_back({1'b1, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input logic r, input logic o, input logic [31:0] np,
                                 input logic mr, input logic orr);
        rst       = r;
        override  = o;
        newpc     = np;
        mem_ready = mr;
        out_ready = orr;
        step();
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        logic        mv[8];
        logic        ov[8];
        logic [31:0] ma[8];
        logic [31:0] opc[8];
        logic [31:0] drained[4];
        logic [31:0] first_pc, first_ins;
        int          acc, got, rv;
        logic        seen;

        @(negedge clk);

        // Reset state and streaming start-up
        lat_min = 1; lat_max = 1;
        doReset(3);
        checkOutput("rst_mem_valid", obs_mem_valid, 1'b0);
        checkOutput("rst_out_valid", obs_out_valid, 1'b0);
        checkOutput("rst_instruction", obs_instr, RINST);
        checkOutput("rst_outpc", obs_outpc, RPC);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
            mv[i] = obs_mem_valid; ov[i] = obs_out_valid;
            ma[i] = obs_mem_addr;  opc[i] = obs_outpc;
        end
        checkOutput("first_req_valid", mv[0], 1'b1);
        checkOutput("first_req_addr", ma[0], 32'h0);
        checkOutput("no_bypass", ov[1], 1'b0);
        checkOutput("first_out_valid", ov[2], 1'b1);
        for (int i = 0; i < 4; i++) checkOutput("stream_outpc", opc[i+2], 32'(4 * i));

        // Full queue with a stalled consumer, then drain in order
        doReset(2);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            if (obs_mem_valid) acc++;
        end
        checkOutput("full_accepts", acc, 4);
        checkOutput("full_mem_valid", obs_mem_valid, 1'b0);
        checkOutput("full_out_valid", obs_out_valid, 1'b1);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
            if (obs_out_valid && got < 4) begin
                drained[got] = obs_outpc;
                got++;
            end
        end
        checkOutput("drain_count", got, 4);
        for (int i = 0; i < got; i++) checkOutput("drain_outpc", drained[i], 32'(4 * i));

        // Redirect with three requests outstanding at 3-cycle latency
        lat_min = 3; lat_max = 3;
        doReset(2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        rv = mem_rvalid ? 1 : 0;
        seen = 1'b0;
        first_pc = '0; first_ins = '0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (obs_out_valid) begin
                seen = 1'b1;
                first_pc = obs_outpc;
                first_ins = obs_instr;
            end else begin
                rv += mem_rvalid ? 1 : 0;
            end
        end
        checkOutput("redir_seen", seen, 1'b1);
        if (seen) begin
            checkOutput("redir_outpc", first_pc, 32'h100);
            checkOutput("redir_instr", first_ins, hash(32'h100));
            checkOutput("redir_dropped", rv - 1, 3);
        end

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        doReset(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
        checkOutput("coll_out_valid", obs_out_valid, 1'b1);
        checkOutput("coll_no_req", obs_mem_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("coll_empty", obs_out_valid, 1'b0);
        checkOutput("coll_mem_valid", obs_mem_valid, 1'b1);
        checkOutput("coll_mem_addr", obs_mem_addr, 32'h40);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Address wrap at the top of the address space
        doReset(2);
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("wrap_addr_hi", obs_mem_addr, 32'hFFFFFFFC);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("wrap_addr_lo", obs_mem_addr, 32'h00000000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

`ifdef FETCH_MISALIGN_EN
        // Unaligned redirect traps until the next redirect
        doReset(2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checkOutput("trap_out_valid", obs_out_valid, 1'b1);
            checkOutput("trap_misaligned", obs_mis, 1'b1);
            checkOutput("trap_outpc", obs_outpc, 32'h102);
            checkOutput("trap_instr", obs_instr, RINST);
            checkOutput("trap_no_req", obs_mem_valid, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("trap_popped", obs_out_valid, 1'b0);
        checkOutput("trap_still_idle", obs_mem_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("trap_resume_valid", obs_mem_valid, 1'b1);
        checkOutput("trap_resume_addr", obs_mem_addr, 32'h200);
`endif

        // Randomized traffic against the model
        lat_min = 1; lat_max = 5;
        doReset(2);
        for (int i = 0; i < 3000; i++) begin
            logic        r, o, mr, orr;
            logic [31:0] np;
            r   = ($urandom_range(0, 199) == 0);
            o   = ($urandom_range(0, 19) == 0);
            np  = $urandom;
            if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) np[31:4] = 28'hFFFFFFF;
            mr  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 6);
            applyStimulus(r, o, np, mr, orr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
